// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage MIPS stall/flush and forwarding control driven by a shadow pipeline.
// Define MD_UNIT_EN to build the mult/div busy counter and its HI/LO stall.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int SEL_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic [1:0]       tuse_rs_D,
  input  logic [1:0]       tuse_rt_D,
  input  logic [4:0]       a3_D,
  input  logic [1:0]       tnew_D,
  input  logic [1:0]       src_D,
  input  logic             md_start_D,
  input  logic             md_div_D,
  input  logic             md_use_D,
  output logic             enPC,
  output logic             enD,
  output logic             clrE,
  output logic [SEL_W-1:0] mfcmp1dSel,
  output logic [SEL_W-1:0] mfcmp2dSel,
  output logic [SEL_W-1:0] mfaluaeSel,
  output logic [SEL_W-1:0] mfalubeSel,
  output logic [SEL_W-1:0] mfdmSel,
  output logic             md_busy
);
  logic [4:0] rs_e_q, rt_e_q, a3_e_q, rt_m_q, a3_m_q, a3_w_q;
  logic [1:0] tnew_e_q, src_e_q, tnew_m_q, src_m_q, src_w_q;
  logic       stall, stall_rs, stall_rt, md_stall, busy;

  function automatic logic hit(input logic [4:0] r, input logic [4:0] a3);
    return r != 5'd0 && r == a3;
  endfunction

  // W-stage select: ALU/DM/PC results map onto 3/4/5
  function automatic logic [SEL_W-1:0] sel_w(input logic [4:0] r, input logic [4:0] a3,
                                             input logic [1:0] src);
    return hit(r, a3) ? SEL_W'(src) + SEL_W'(3) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] fwd(input logic [4:0] r, input logic [4:0] a3m,
                                           input logic [1:0] tnewm, input logic [1:0] srcm,
                                           input logic [4:0] a3w, input logic [1:0] srcw);
    return (hit(r, a3m) && tnewm == 2'd0) ? ((srcm == 2'd2) ? SEL_W'(2) : SEL_W'(1))
                                          : sel_w(r, a3w, srcw);
  endfunction

  assign stall_rs = (hit(rs_D, a3_e_q) && tuse_rs_D < tnew_e_q) ||
                    (hit(rs_D, a3_m_q) && tuse_rs_D < tnew_m_q);
  assign stall_rt = (hit(rt_D, a3_e_q) && tuse_rt_D < tnew_e_q) ||
                    (hit(rt_D, a3_m_q) && tuse_rt_D < tnew_m_q);
  assign stall    = stall_rs | stall_rt | md_stall;

  assign enPC       = !reset || !stall;
  assign enD        = !reset || !stall;
  assign clrE       = reset && stall;
  assign mfcmp1dSel = reset ? fwd(rs_D, a3_m_q, tnew_m_q, src_m_q, a3_w_q, src_w_q) : '0;
  assign mfcmp2dSel = reset ? fwd(rt_D, a3_m_q, tnew_m_q, src_m_q, a3_w_q, src_w_q) : '0;
  assign mfaluaeSel = reset ? fwd(rs_e_q, a3_m_q, tnew_m_q, src_m_q, a3_w_q, src_w_q) : '0;
  assign mfalubeSel = reset ? fwd(rt_e_q, a3_m_q, tnew_m_q, src_m_q, a3_w_q, src_w_q) : '0;
  assign mfdmSel    = reset ? sel_w(rt_m_q, a3_w_q, src_w_q) : '0;
  assign md_busy    = reset && busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_e_q   <= '0;
      rt_e_q   <= '0;
      a3_e_q   <= '0;
      tnew_e_q <= '0;
      src_e_q  <= '0;
      rt_m_q   <= '0;
      a3_m_q   <= '0;
      tnew_m_q <= '0;
      src_m_q  <= '0;
      a3_w_q   <= '0;
      src_w_q  <= '0;
    end else begin
      rs_e_q   <= stall ? '0 : rs_D;
      rt_e_q   <= stall ? '0 : rt_D;
      a3_e_q   <= stall ? '0 : a3_D;
      tnew_e_q <= stall ? '0 : tnew_D;
      src_e_q  <= stall ? '0 : src_D;
      rt_m_q   <= rt_e_q;
      a3_m_q   <= a3_e_q;
      tnew_m_q <= (tnew_e_q != 2'd0) ? tnew_e_q - 2'd1 : 2'd0;
      src_m_q  <= src_e_q;
      a3_w_q   <= a3_m_q;
      src_w_q  <= src_m_q;
    end
  end

`ifdef MD_UNIT_EN
  localparam int CW = $clog2((DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES) + 1);
  logic          mds_e_q, mdd_e_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign busy     = cnt_q != '0;
  assign md_stall = md_use_D && (mds_e_q || busy);
  // a start in E reloads the counter even if a previous operation is still counting
  assign cnt_d    = mds_e_q ? (mdd_e_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES))
                  : busy ? cnt_q - CW'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mds_e_q <= 1'b0;
      mdd_e_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mds_e_q <= !stall && md_start_D;
      mdd_e_q <= !stall && md_div_D;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_md;
  assign unused_md = ^{md_start_D, md_div_D, md_use_D};
  assign busy      = 1'b0;
  assign md_stall  = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench replaying hand-scheduled instruction streams through hazard_ctrl.
module tb_hazard_ctrl;
  logic       clk, reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, src_D;
  logic       md_start_D, md_div_D, md_use_D;
  logic       enPC, enD, clrE, md_busy;
  logic [3:0] mfcmp1dSel, mfcmp2dSel, mfaluaeSel, mfalubeSel, mfdmSel;

  typedef struct {
    logic       rst, mds, mdd, mdu;
    logic [4:0] rs, rt, a3;
    logic [1:0] tur, tut, tnew, src;
  } in_t;
  typedef struct {
    int stall, s1, s2, sa, sb, sdm, busy;
  } ex_t;

  ex_t q[$];
  int  checks = 0, errors = 0, n = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D),
    .tuse_rt_D(tuse_rt_D), .a3_D(a3_D), .tnew_D(tnew_D), .src_D(src_D),
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
    .enPC(enPC), .enD(enD), .clrE(clrE), .mfcmp1dSel(mfcmp1dSel), .mfcmp2dSel(mfcmp2dSel),
    .mfaluaeSel(mfaluaeSel), .mfalubeSel(mfalubeSel), .mfdmSel(mfdmSel), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s@c%0d got %0d exp %0d", tag, n, got, exp);
    end
  endtask

  function automatic in_t ins(input int rs, input int rt, input int tur, input int tut,
                              input int a3, input int tnew, input int src);
    in_t i;
    i.rst = 1'b1; i.mds = 1'b0; i.mdd = 1'b0; i.mdu = 1'b0;
    i.rs = 5'(rs); i.rt = 5'(rt); i.a3 = 5'(a3);
    i.tur = 2'(tur); i.tut = 2'(tut); i.tnew = 2'(tnew); i.src = 2'(src);
    return i;
  endfunction

  function automatic in_t nop();
    return ins(0, 0, 3, 3, 0, 0, 0);
  endfunction

  function automatic in_t md(input int start, input int dv, input int a3);
    in_t i = ins(0, 0, 3, 3, a3, (a3 != 0) ? 1 : 0, 0);
    i.mds = 1'(start); i.mdd = 1'(dv); i.mdu = 1'b1;
    return i;
  endfunction

  function automatic in_t rst0(input in_t i);
    in_t r = i;
    r.rst = 1'b0;
    return r;
  endfunction

  function automatic ex_t ex(input int stall, input int s1 = 0, input int s2 = 0, input int sa = 0,
                             input int sb = 0, input int sdm = 0, input int busy = 0);
    ex_t e;
    e.stall = stall; e.s1 = s1; e.s2 = s2; e.sa = sa; e.sb = sb; e.sdm = sdm; e.busy = busy;
    return e;
  endfunction

  task automatic cyc(input in_t i, input ex_t e);
    reset = i.rst; rs_D = i.rs; rt_D = i.rt; tuse_rs_D = i.tur; tuse_rt_D = i.tut;
    a3_D = i.a3; tnew_D = i.tnew; src_D = i.src;
    md_start_D = i.mds; md_div_D = i.mdd; md_use_D = i.mdu;
    q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1 n++;
  endtask

  always @(negedge clk) begin
    ex_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("enPC", int'(enPC), e.stall ? 0 : 1);
      chk("enD", int'(enD), e.stall ? 0 : 1);
      chk("clrE", int'(clrE), e.stall);
      chk("cmp1", int'(mfcmp1dSel), e.s1);
      chk("cmp2", int'(mfcmp2dSel), e.s2);
      chk("aluA", int'(mfaluaeSel), e.sa);
      chk("aluB", int'(mfalubeSel), e.sb);
      chk("dm", int'(mfdmSel), e.sdm);
      chk("busy", int'(md_busy), e.busy);
    end
  end

  initial begin
    // reset
    cyc(rst0(nop()), ex(0));
    cyc(rst0(nop()), ex(0));
    // addu $1 then beq $1: one stall, then forward ALUC_M
    cyc(ins(0, 0, 3, 3, 1, 1, 0), ex(0));
    cyc(ins(1, 0, 0, 3, 0, 0, 0), ex(1));
    cyc(ins(1, 0, 0, 3, 0, 0, 0), ex(0, 1));
    cyc(nop(), ex(0, 0, 0, 3));
    cyc(nop(), ex(0));
    cyc(nop(), ex(0));
    // lw $2 then addu rs=$2: one stall, then DMRD_W into E
    cyc(ins(0, 0, 3, 3, 2, 2, 1), ex(0));
    cyc(ins(2, 0, 1, 3, 4, 1, 0), ex(1));
    cyc(ins(2, 0, 1, 3, 4, 1, 0), ex(0));
    cyc(nop(), ex(0, 0, 0, 4));
    cyc(nop(), ex(0));
    cyc(nop(), ex(0));
    // jal/nop/jr -> pc4_M, jal/nop/nop/jr -> pc4_W
    cyc(nop(), ex(0));
    cyc(ins(0, 0, 3, 3, 31, 1, 2), ex(0));
    cyc(nop(), ex(0));
    cyc(ins(31, 0, 0, 3, 0, 0, 0), ex(0, 2));
    cyc(nop(), ex(0, 0, 0, 5));
    cyc(ins(0, 0, 3, 3, 31, 1, 2), ex(0));
    cyc(nop(), ex(0));
    cyc(nop(), ex(0));
    cyc(ins(31, 0, 0, 3, 0, 0, 0), ex(0, 5));
    cyc(nop(), ex(0));
    cyc(nop(), ex(0));
    cyc(nop(), ex(0));
    // lw $3 then sw rt=$3: no stall, no E forward, DMRD_W into M
    cyc(ins(0, 0, 3, 3, 3, 2, 1), ex(0));
    cyc(ins(0, 3, 3, 2, 0, 0, 0), ex(0));
    cyc(nop(), ex(0));
    cyc(nop(), ex(0, 0, 0, 0, 0, 4));
    cyc(nop(), ex(0));
    cyc(nop(), ex(0));
    cyc(nop(), ex(0));
    // $0 never stalls or forwards
    cyc(ins(0, 0, 3, 3, 0, 1, 0), ex(0));
    cyc(ins(0, 0, 0, 0, 0, 0, 0), ex(0));
    cyc(nop(), ex(0));
    cyc(nop(), ex(0));
    // reset in the middle of a load-use stall
    cyc(ins(0, 0, 3, 3, 7, 2, 1), ex(0));
    cyc(ins(7, 0, 0, 3, 0, 0, 0), ex(1));
    cyc(rst0(ins(7, 0, 0, 3, 0, 0, 0)), ex(0));
    cyc(ins(7, 0, 0, 3, 0, 0, 0), ex(0));
    cyc(nop(), ex(0));
`ifdef MD_UNIT_EN
    // mult: stall while in E plus 5 busy cycles
    cyc(md(1, 0, 0), ex(0));
    cyc(md(0, 0, 8), ex(1));
    for (int k = 0; k < 5; k++) cyc(md(0, 0, 8), ex(1, 0, 0, 0, 0, 0, 1));
    cyc(md(0, 0, 8), ex(0));
    // div: 10 busy cycles
    cyc(md(1, 1, 0), ex(0));
    cyc(md(0, 0, 8), ex(1));
    for (int k = 0; k < 10; k++) cyc(md(0, 0, 8), ex(1, 0, 0, 0, 0, 0, 1));
    cyc(md(0, 0, 8), ex(0));
    // reset during div busy
    cyc(md(1, 1, 0), ex(0));
    cyc(md(0, 0, 8), ex(1));
    cyc(md(0, 0, 8), ex(1, 0, 0, 0, 0, 0, 1));
    cyc(rst0(md(0, 0, 8)), ex(0));
    cyc(md(0, 0, 8), ex(0));
    cyc(nop(), ex(0));
`else
    // without the MD unit, HI/LO users never stall
    cyc(md(1, 1, 0), ex(0));
    cyc(md(0, 0, 8), ex(0));
    cyc(md(0, 0, 8), ex(0));
    cyc(nop(), ex(0));
`endif
    if (q.size() != 0) chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath (F/D/E/M/W).
- Tracks the destination register, result-ready time (Tnew) and result source of every in-flight instruction in a shadow pipeline.
- From that state it drives stall/flush (enPC, enD, clrE) and every forwarding-mux select (mfcmp1dSel, mfcmp2dSel, mfaluaeSel, mfalubeSel, mfdmSel).
- Contains the mult/div busy counter that stalls HI/LO users.

Parameters:
MULT_CYCLES, 5, busy cycles after mult/multu enters E
DIV_CYCLES, 10, busy cycles after div/divu enters E
SEL_W, 4, width of forwarding selects

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
rs_D  input  5  rs field of instr in D
rt_D  input  5  rt field of instr in D
tuse_rs_D  input  2  cycles until rs needed (0 branch/jr, 1 ALU, 2 store data, 3 unused)
tuse_rt_D  input  2  same for rt
a3_D  input  5  destination reg of instr in D (0 = none)
tnew_D  input  2  Tnew at E entry: ALU 1, load 2, link 1
src_D  input  2  result source: 0 ALU, 1 DM, 2 PC link
md_start_D  input  1  D instr is mult/multu/div/divu
md_div_D  input  1  start is a divide
md_use_D  input  1  D instr needs HI/LO unit (mf/mt hi/lo, mult, div)
enPC  output  1  PC write enable
enD  output  1  D register enable
clrE  output  1  E register clear (bubble)
mfcmp1dSel  output  SEL_W  D-stage rs forward select
mfcmp2dSel  output  SEL_W  D-stage rt forward select
mfaluaeSel  output  SEL_W  E-stage rs forward select
mfalubeSel  output  SEL_W  E-stage rt forward select
mfdmSel  output  SEL_W  M-stage store-data forward select
md_busy  output  1  mult/div counter nonzero

Behaviour:
- Select encoding: 0 stage's own value, 1 ALUC_M, 2 pc4_M (link), 3 ALUC_W, 4 DMRD_W, 5 pc4_W. mfdmSel uses only 0/3/4/5.
- Shadow pipe registers:
  - E: rs, rt, a3, tnew, src, mdstart, mddiv
  - M: rt, a3, tnew, src
  - W: a3, src
- Shadow pipe advance, every clock:
  - E <- D fields, or all-zero bubble when stall=1.
  - M <- E with tnew = max(tnew-1, 0).
  - W <- M.
- Match rule: reg != 0, stage a3 == reg.
- Stall rule:
  - stall_rs = match(rs_D, E) and tuse_rs_D < tnew_E, or match(rs_D, M) and tuse_rs_D < tnew_M. stall_rt is the same for rt.
  - md_stall = md_use_D and (mdstart_E or md_busy).
  - stall = stall_rs | stall_rt | md_stall.
  - enPC = enD = ~stall; clrE = stall. All combinational, same cycle.
- D selects:
  - Priority M over W.
  - M match with tnew_M==0: src ALU -> 1, PC -> 2.
  - Else W match: ALU -> 3, DM -> 4, PC -> 5.
  - Else 0.
- E selects: same rule using rs_E/rt_E.
- mfdmSel: rt_M matches W -> 3/4/5 by src_W, else 0.
- Register $0: never matches; never stalls, never forwards.
- MD counter:
  - When the E entry holds mdstart, the counter loads DIV_CYCLES if mddiv, else MULT_CYCLES.
  - Otherwise it decrements while nonzero.
  - md_busy = counter != 0.
  - Load wins over decrement.
- Reset (reset==0 at a clock edge):
  - All shadow entries zeroed; counter 0.
  - While reset is low, outputs are forced: enPC=1, enD=1, clrE=0, all selects 0, md_busy=0.
  - A reset arriving mid-stall or mid-divide aborts both; the first cycle after release has no stall unless the new D inputs cause one.

Optional Feature:
- Macro: MD_UNIT_EN.
- Defined: MD counter, md_stall and md_busy are present as described.
- Undefined:
  - No counter logic; md_stall=0 and md_busy tied 0.
  - md_start_D, md_div_D and md_use_D are ignored.
  - Shadow E entry omits mdstart/mddiv.

Test Plan:
1. Cycle n: D=addu a3=1, tnew=1, src ALU. Cycle n+1: D=beq rs=1, tuse_rs=0.
   - -> n+1: enPC=0, enD=0, clrE=1.
   - -> n+2: no stall, mfcmp1dSel=1.
2. lw a3=2, tnew=2, src DM, then addu rs=2, tuse=1.
   - -> one stall cycle.
   - -> next cycle mfaluaeSel=4 (lw in W), enPC=1.
3. jal a3=31, tnew=1, src PC, then nop, then jr rs=31, tuse=0.
   - -> no stall; jr in D sees mfcmp1dSel=2.
   - -> with two nops between jal and jr: mfcmp1dSel=5.
4. lw a3=3, then sw rt=3, tuse_rt=2.
   - -> no stall.
   - -> sw in E: mfalubeSel=0 (lw in M, tnew 1).
   - -> next cycle mfdmSel=4.
5. mult enters E, then mflo (md_use) held in D.
   - -> stall in the cycle mult is in E, then 5 more (md_busy=1 throughout counter 5..1).
   - -> released when counter reaches 0.
   - -> div variant: 10 busy cycles.
6. Edge cases:
   - addu a3=0 followed by beq rs=0 -> no stall, selects 0.
   - reset=0 asserted during div busy -> md_busy=0 next cycle; shadow pipe cleared; no forwarding afterwards.
